// File: rtl/xbar_mem_slave.sv
// xbar_mem_slave: word-addressed single-port memory slave behind one
// crossbar slave port, with a fixed number of wait states before ack.
//
// Parameters:
//   AW          word-address width (depth 2^AW x 32 bits)
//   WAIT_CYCLES wait states between acceptance and ack (0..15)
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   s_req               request, held high by the master until s_ack
//   s_cmd               1 = write, 0 = read
//   s_addr              byte address; word index is s_addr[AW+1:2]
//   s_wdata             write data
//   s_ack               one-cycle completion pulse (registered)
//   s_rdata             read data, valid with s_ack (registered)
//   busy                high whenever the slave is not IDLE (registered)
// Optional feature:
//   XBAR_MEM_SLAVE_RANGE_CHECK_EN  out-of-range addresses (s_addr[30:AW+2]
//   nonzero) drop writes and return 32'hDEAD_BEEF on reads.
module xbar_mem_slave #(
  parameter int unsigned AW          = 8,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_req,
  input  logic        s_cmd,
  input  logic [31:0] s_addr,
  input  logic [31:0] s_wdata,
  output logic        s_ack,
  output logic [31:0] s_rdata,
  output logic        busy
);

  localparam int unsigned DW       = 32;
  localparam int unsigned CW       = 4;
  localparam int unsigned DEPTH    = 1 << AW;
  localparam logic [DW-1:0] OOR_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          capture, enter_ack;

  logic          cmd_q;
  logic [AW-1:0] idx_q;
  logic [DW-1:0] wdata_q;
  logic          oor_q;

  logic          in_oor;
  logic          cur_cmd;
  logic [AW-1:0] cur_idx;
  logic [DW-1:0] cur_wdata;
  logic          cur_oor;
  logic          mem_we;

  logic [DW-1:0] mem [DEPTH];

  // Out-of-range detection on the live address (captured at acceptance)
`ifdef XBAR_MEM_SLAVE_RANGE_CHECK_EN
  assign in_oor = |s_addr[30:AW+2];
`else
  assign in_oor = 1'b0;
`endif

  // Slave-select bit and byte offset carry no meaning inside the slave
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_addr[31], s_addr[30:AW+2], s_addr[1:0]};

  // With zero wait states ACK is entered on the acceptance edge itself,
  // so the transaction must come from the live inputs rather than the
  // capture registers.
  always_comb begin
    if (state == ST_IDLE) begin
      cur_cmd   = s_cmd;
      cur_idx   = s_addr[AW+1:2];
      cur_wdata = s_wdata;
      cur_oor   = in_oor;
    end else begin
      cur_cmd   = cmd_q;
      cur_idx   = idx_q;
      cur_wdata = wdata_q;
      cur_oor   = oor_q;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    capture    = 1'b0;
    enter_ack  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (s_req) begin
          capture = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_next = ST_ACK;
            enter_ack  = 1'b1;
          end else begin
            state_next = ST_WAIT;
            cnt_next   = CW'(WAIT_CYCLES - 1);
          end
        end
      end
      ST_WAIT: begin
        if (!s_req) begin
          // master withdrew (port re-granted): abort silently
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else if (cnt == '0) begin
          state_next = ST_ACK;
          enter_ack  = 1'b1;
        end else begin
          cnt_next = cnt - CW'(1);
        end
      end
      ST_ACK:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // State, capture and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      cmd_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      oor_q   <= 1'b0;
      s_ack   <= 1'b0;
      s_rdata <= '0;
      busy    <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      busy  <= (state_next != ST_IDLE);
      if (capture) begin
        cmd_q   <= s_cmd;
        idx_q   <= s_addr[AW+1:2];
        wdata_q <= s_wdata;
        oor_q   <= in_oor;
      end
      if (enter_ack) begin
        s_ack <= 1'b1;
        if (cur_cmd)      s_rdata <= '0;
        else if (cur_oor) s_rdata <= OOR_DATA;
        else              s_rdata <= mem[cur_idx];
      end else begin
        s_ack   <= 1'b0;
        s_rdata <= '0;
      end
    end
  end

  // Reset gates the write so a transaction cut off by reset never lands
  assign mem_we = enter_ack && cur_cmd && !cur_oor && !reset;

  // Storage array: never reset
  always_ff @(posedge clk) begin
    if (mem_we) mem[cur_idx] <= cur_wdata;
  end

endmodule

// File: tb/tb_xbar_mem_slave.sv
// Directed bench for xbar_mem_slave: instance 0 has WAIT_CYCLES=0,
// instance 1 has WAIT_CYCLES=2; both share clock and reset.
module tb_xbar_mem_slave;

  logic        clk = 1'b0;
  logic        reset;
  logic        req   [2];
  logic        cmd   [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic        ack   [2];
  logic [31:0] rdata [2];
  logic        busy  [2];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  xbar_mem_slave #(.AW(8), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .reset(reset),
    .s_req(req[0]), .s_cmd(cmd[0]), .s_addr(addr[0]), .s_wdata(wdata[0]),
    .s_ack(ack[0]), .s_rdata(rdata[0]), .busy(busy[0])
  );

  xbar_mem_slave #(.AW(8), .WAIT_CYCLES(2)) u_w2 (
    .clk(clk), .reset(reset),
    .s_req(req[1]), .s_cmd(cmd[1]), .s_addr(addr[1]), .s_wdata(wdata[1]),
    .s_ack(ack[1]), .s_rdata(rdata[1]), .busy(busy[1])
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Full transaction: request, wait for ack (bounded), check latency and
  // pulse width, return the data seen with ack.
  task automatic txn(input int i, input logic c, input logic [31:0] a,
                     input logic [31:0] wd, input int exp_lat,
                     output logic [31:0] rd);
    int n;
    req[i] = 1'b1; cmd[i] = c; addr[i] = a; wdata[i] = wd;
    n = 0;
    do begin
      tick();
      n++;
      if (n == 1) chk("busy_after_accept", 32'(busy[i]), 32'd1);
    end while (ack[i] !== 1'b1 && n < 20);
    chk("ack_latency", 32'(n), 32'(exp_lat));
    rd = rdata[i];
    if (c) chk("wr_rdata_zero", rd, 32'h0);
    req[i] = 1'b0;
    tick();
    chk("ack_pulse_end", 32'(ack[i]), 32'd0);
    chk("rdata_after_ack", rdata[i], 32'h0);
  endtask

  initial begin
    logic [31:0] rd;
    int n;

    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; cmd[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
    end
    tick(); tick();
    for (int i = 0; i < 2; i++) begin
      chk("reset_ack", 32'(ack[i]), 32'd0);
      chk("reset_rdata", rdata[i], 32'h0);
      chk("reset_busy", 32'(busy[i]), 32'd0);
    end
    reset = 1'b0;
    tick();

    // Basic write then read, 2 wait states
    txn(1, 1'b1, 32'h8000_0010, 32'h1234_5678, 3, rd);
    txn(1, 1'b0, 32'h8000_0010, 32'h0, 3, rd);
    chk("basic_read", rd, 32'h1234_5678);

    // Preloads for later tests
    txn(1, 1'b1, 32'h8000_0000, 32'h0000_7777, 3, rd);
    txn(1, 1'b1, 32'h0000_0034, 32'h5555_5555, 3, rd);
    txn(1, 1'b1, 32'h0000_0040, 32'h0000_00AA, 3, rd);

    // Back-to-back, zero wait states, req held high throughout
    req[0] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cmd[0]   = (k < 4);
      addr[0]  = 32'((k % 4) * 4);
      wdata[0] = 32'hA0A0_0000 + 32'(k);
      tick();
      chk("b2b_ack", 32'(ack[0]), 32'd1);
      if (k >= 4) chk("b2b_rdata", rdata[0], 32'hA0A0_0000 + 32'(k - 4));
      else        chk("b2b_wr_rdata", rdata[0], 32'h0);
      if (k == 7) req[0] = 1'b0;
      tick();
      chk("b2b_gap", 32'(ack[0]), 32'd0);
    end

    // Abort: read accepted, req dropped in first WAIT cycle
    req[1] = 1'b1; cmd[1] = 1'b0; addr[1] = 32'h20;
    tick();
    chk("abort_busy_wait", 32'(busy[1]), 32'd1);
    req[1] = 1'b0;
    tick();
    chk("abort_busy_fall", 32'(busy[1]), 32'd0);
    chk("abort_no_ack", 32'(ack[1]), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("abort_quiet", 32'(ack[1]), 32'd0);
    end
    txn(1, 1'b1, 32'h20, 32'hCAFE_0001, 3, rd);
    txn(1, 1'b0, 32'h20, 32'h0, 3, rd);
    chk("abort_then_write", rd, 32'hCAFE_0001);

    // Inputs ignored after acceptance
    req[1] = 1'b1; cmd[1] = 1'b1; addr[1] = 32'h30; wdata[1] = 32'h1111_1111;
    tick();
    cmd[1] = 1'b0; addr[1] = 32'h34; wdata[1] = 32'h2222_2222;
    n = 1;
    while (ack[1] !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("sampled_latency", 32'(n), 32'd3);
    chk("sampled_is_write", rdata[1], 32'h0);
    req[1] = 1'b0;
    tick();
    txn(1, 1'b0, 32'h30, 32'h0, 3, rd);
    chk("sampled_data", rd, 32'h1111_1111);
    txn(1, 1'b0, 32'h34, 32'h0, 3, rd);
    chk("sampled_other_idx", rd, 32'h5555_5555);

    // Reset in the middle of WAIT of a write
    req[1] = 1'b1; cmd[1] = 1'b1; addr[1] = 32'h40; wdata[1] = 32'hFFFF_0000;
    tick(); tick();
    chk("rst_wait_busy", 32'(busy[1]), 32'd1);
    reset = 1'b1;
    req[1] = 1'b0;
    #1;
    chk("rst_wait_ack", 32'(ack[1]), 32'd0);
    chk("rst_wait_rdata", rdata[1], 32'h0);
    chk("rst_wait_busy0", 32'(busy[1]), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    txn(1, 1'b0, 32'h40, 32'h0, 3, rd);
    chk("rst_dropped_write", rd, 32'h0000_00AA);

    // Reset while in ACK clears read data immediately
    req[1] = 1'b1; cmd[1] = 1'b0; addr[1] = 32'h30;
    n = 0;
    do begin
      tick();
      n++;
    end while (ack[1] !== 1'b1 && n < 20);
    chk("rst_ack_data", rdata[1], 32'h1111_1111);
    reset = 1'b1;
    req[1] = 1'b0;
    #1;
    chk("rst_ack_ack", 32'(ack[1]), 32'd0);
    chk("rst_ack_rdata", rdata[1], 32'h0);
    tick();
    reset = 1'b0;
    tick();

    // Upper address bits: range check or aliasing
    txn(1, 1'b0, 32'h8000_1000, 32'h0, 3, rd);
`ifdef XBAR_MEM_SLAVE_RANGE_CHECK_EN
    chk("range_read", rd, 32'hDEAD_BEEF);
`else
    chk("alias_read", rd, 32'h0000_7777);
`endif
    txn(1, 1'b1, 32'h8000_1000, 32'h0000_9999, 3, rd);
    txn(1, 1'b0, 32'h8000_0000, 32'h0, 3, rd);
`ifdef XBAR_MEM_SLAVE_RANGE_CHECK_EN
    chk("range_write_dropped", rd, 32'h0000_7777);
`else
    chk("alias_write", rd, 32'h0000_9999);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/xbar_mem_slave.md
# xbar_mem_slave

Word-addressed single-port memory slave that sits directly downstream of one crossbar slave port. It consumes the request bundle the crossbar forwards (`req`, `cmd`, `addr`, `wdata`) and returns the acknowledge/read-data pair (`ack`, `rdata`) that the crossbar routes back to the owning master. The slave has a programmable wait-state count, so designs can model slow targets behind the crossbar.

## Interface
- `AW`, default 8: word-address width. Memory depth is 2^AW words of 32 bits.
- `WAIT_CYCLES`, default 2: wait states inserted between request acceptance and `ack`. The legal range is 0..15.
- `clk`  in  1: clock. All state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `s_req`  in  1: request. The master holds it high until it sees `s_ack`.
- `s_cmd`  in  1: 1 = write, 0 = read.
- `s_addr`  in  32: byte address. The word index is `s_addr[AW+1:2]`. Bit 31 is the crossbar slave select and is ignored here.
- `s_wdata`  in  32: write data.
- `s_ack`  out  1: one-cycle completion pulse, registered.
- `s_rdata`  out  32: read data, registered. Valid only while `s_ack`=1.
- `busy`  out  1: high in every state other than IDLE.

## Operation
- The FSM has three states: IDLE, WAIT and ACK.
- **IDLE**
  - With `s_req`=1 at the clock edge, the slave captures `s_cmd`, the word index and `s_wdata` into internal registers.
  - If `WAIT_CYCLES`=0 it goes to ACK; otherwise it goes to WAIT with `cnt`=`WAIT_CYCLES`-1.
- **WAIT**
  - If `s_req`=0, the transaction is aborted: the slave returns to IDLE with no write and no ack. This covers the crossbar arbiter re-granting the port away mid-transaction.
  - Else if `cnt`=0, it goes to ACK. Otherwise `cnt` decrements.
- **Entering ACK** (same edge)
  - Write: `mem[idx]` <= captured wdata, and `s_rdata` <= 0.
  - Read: `s_rdata` <= `mem[idx]`.
  - `s_ack` <= 1.
- **ACK**
  - Lasts exactly one cycle, then returns to IDLE. `s_ack` <= 0 and `s_rdata` <= 0 on exit.
  - A `s_req` still high in the cycle after ACK is treated as a new transaction.
- Inputs are sampled only at acceptance. Changes to `s_addr`, `s_cmd` or `s_wdata` during WAIT have no effect.
- **Reset** (any time, including mid-WAIT or in ACK):
  - State goes to IDLE; `cnt`=0.
  - `s_ack`=0, `s_rdata`=0, `busy`=0.
  - Any pending write is dropped.
  - Memory contents are not cleared; unwritten words read as X in simulation.
- `cnt` is 4 bits wide. Values of `WAIT_CYCLES` above 15 are not supported.

## Timing
- Request cycle T0 has `s_req` sampled high at its closing edge. `s_ack` is high in cycle T0+`WAIT_CYCLES`+1.
- With `WAIT_CYCLES`=0, `s_ack` is high in cycle T0+1.
- Back-to-back: a master that drops or re-presents `s_req` on the edge where it samples `s_ack` gets a new acceptance no earlier than the cycle after ACK. Minimum transaction spacing is `WAIT_CYCLES`+2 cycles.
- A write is visible to a read accepted in any later transaction; there is no read-during-write hazard.
- No combinational path from any input to `s_ack` or `s_rdata`.

## Configuration
- Macro: `XBAR_MEM_SLAVE_RANGE_CHECK_EN`.
- **Defined:**
  - A transaction is out of range when captured `s_addr[30:AW+2]` is nonzero.
  - An out-of-range write is ignored (memory unchanged) but still acked.
  - An out-of-range read returns `s_rdata`=32'hDEAD_BEEF with `s_ack`.
  - Wait-state timing is unchanged.
- **Undefined:** upper address bits are ignored and addresses alias modulo 2^AW words.

## Test plan
- Reset, then write 32'h1234_5678 to address 32'h8000_0010, then read the same address (`WAIT_CYCLES`=2): each `s_ack` is a 1-cycle pulse 3 cycles after acceptance, and the read returns 32'h1234_5678.
- `WAIT_CYCLES`=0, four back-to-back writes to words 0..3 followed by four reads: an ack every 2 cycles and data read back in order.
- Read accepted, then `s_req` dropped in the first WAIT cycle: no `s_ack`, `busy` falls next cycle, and a subsequent write to the same word is acked normally.
- Write accepted, `s_wdata` and `s_addr` changed during WAIT: memory holds the value captured at acceptance, at the original index.
- Assert `reset` during WAIT of a write: `s_ack`=0 and `s_rdata`=0 immediately, and a subsequent read of that word shows it was not written (old value retained).
- Read of 32'h8000_1000 with `AW`=8. With `XBAR_MEM_SLAVE_RANGE_CHECK_EN`: returns 32'hDEAD_BEEF. Without it: returns `mem[0]`.
